// File: rtl/rc4_key_scheduler_if.sv
// S-RAM writer bus for the RC4 key scheduler.
//   start       run request (edge detected inside the scheduler)
//   secret_key  key bytes, byte 0 in the most significant position
//   sOut        S-RAM read data, valid one cycle after the address
//   sIn/sAddr/sWren  S-RAM write data, address and write enable
//   busy        high while a fill/permute run is in progress
//   finished    one-cycle pulse when the run completes
//   dbg_state   current scheduler FSM state, for checkers
// Handshake: start is a level request whose rising edge launches exactly one
// run while the scheduler is idle; the scheduler owns the S-RAM port until
// finished pulses and ignores further start edges while busy.
// The scheduler uses the slave modport; the driver/RAM side uses master.
interface rc4_key_scheduler_if #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_LENGTH = 8,
    parameter int KEY_BYTES  = 3
);
    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic [RAM_WIDTH-1:0]   sOut;
    logic [RAM_WIDTH-1:0]   sIn;
    logic [RAM_LENGTH-1:0]  sAddr;
    logic                   sWren;
    logic                   busy;
    logic                   finished;
    logic [2:0]             dbg_state;

    modport master (
        output start, secret_key, sOut,
        input  sIn, sAddr, sWren, busy, finished, dbg_state
    );

    modport slave (
        input  start, secret_key, sOut,
        output sIn, sAddr, sWren, busy, finished, dbg_state
    );
endinterface

// File: rtl/rc4_key_scheduler.sv
// RC4 key scheduler: writer side of the shared S-array RAM.
// Fills S[k]=k, then runs the RC4 key-scheduling permutation with the key
// latched at the start edge, then pulses finished for one cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    rc4_key_scheduler_if.slave (start, secret_key, sOut in;
//          sIn, sAddr, sWren, busy, finished, dbg_state out)
// Timing: start-edge cycle T0, fill T1..T256, five cycles per permutation
// step T257..T1536, finished at T1537, idle again at T1538.
module rc4_key_scheduler #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_LENGTH = 8,
    parameter int KEY_BYTES  = 3
) (
    input logic                clk,
    input logic                reset,
    rc4_key_scheduler_if.slave bus
);
    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIW-1:0] KEY_LAST = KIW'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        RD_SI  = 3'd2,
        CALC_J = 3'd3,
        RD_SJ  = 3'd4,
        WR_SI  = 3'd5,
        WR_SJ  = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t                 state;
    logic [RAM_LENGTH-1:0]  i, j;
    logic [RAM_WIDTH-1:0]   si, sj;
    logic [KIW-1:0]         key_idx;
    logic [8*KEY_BYTES-1:0] key_reg;
    logic                   start_q;
    logic [RAM_LENGTH-1:0]  addr_q;
    logic [RAM_WIDTH-1:0]   din_q;
    logic                   wren_q, busy_q, fin_q;
    logic [7:0]             key_byte;
    logic [RAM_LENGTH-1:0]  j_next;
    logic                   start_edge;

    assign start_edge = bus.start & ~start_q;

    // Byte 0 of the key sits in the most significant byte position.
    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (key_idx == KIW'(k)) begin
                key_byte = key_reg[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

    assign j_next = j + RAM_LENGTH'(bus.sOut) + RAM_LENGTH'(key_byte);

    // S[i] arrives in CALC_J and S[j] must be read in that same cycle to keep
    // the five-cycle step, so the address bypasses the register in CALC_J.
    assign bus.sAddr     = (state == CALC_J) ? j_next : addr_q;
    assign bus.sIn       = din_q;
    assign bus.sWren     = wren_q;
    assign bus.busy      = busy_q;
    assign bus.finished  = fin_q;
    assign bus.dbg_state = state;

    // Output registers are loaded with the values belonging to the state
    // being entered, so they are valid throughout that state's cycle.
    always_ff @(posedge clk) begin
        // Tracks start even during reset: a start held through reset is not an edge.
        start_q <= bus.start;
        if (reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            si      <= '0;
            sj      <= '0;
            key_idx <= '0;
            key_reg <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fin_q <= 1'b0;
                    if (start_edge) begin
                        state   <= INIT;
                        i       <= '0;
                        key_reg <= bus.secret_key;
                        addr_q  <= '0;
                        din_q   <= '0;
                        wren_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                INIT: begin
                    if (&i) begin
                        state   <= RD_SI;
                        i       <= '0;
                        j       <= '0;
                        key_idx <= '0;
                        addr_q  <= '0;
                        din_q   <= '0;
                        wren_q  <= 1'b0;
                    end else begin
                        i      <= i + RAM_LENGTH'(1);
                        addr_q <= i + RAM_LENGTH'(1);
                        din_q  <= RAM_WIDTH'(i + RAM_LENGTH'(1));
                        wren_q <= 1'b1;
                    end
                end
                RD_SI: begin
                    state  <= CALC_J;
                    din_q  <= '0;
                    wren_q <= 1'b0;
                end
                CALC_J: begin
                    state  <= RD_SJ;
                    si     <= bus.sOut;
                    j      <= j_next;
                    addr_q <= j_next;
                end
                RD_SJ: begin
                    state  <= WR_SI;
                    sj     <= bus.sOut;
                    addr_q <= i;
                    din_q  <= bus.sOut;
                    wren_q <= 1'b1;
                end
                WR_SI: begin
                    state  <= WR_SJ;
                    addr_q <= j;
                    din_q  <= si;
                    wren_q <= 1'b1;
                end
                WR_SJ: begin
                    key_idx <= (key_idx == KEY_LAST) ? '0 : key_idx + KIW'(1);
                    din_q   <= '0;
                    wren_q  <= 1'b0;
                    if (&i) begin
                        state  <= DONE;
                        addr_q <= '0;
                        busy_q <= 1'b0;
                        fin_q  <= 1'b1;
                    end else begin
                        state  <= RD_SI;
                        i      <= i + RAM_LENGTH'(1);
                        addr_q <= i + RAM_LENGTH'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    fin_q  <= 1'b0;
                    busy_q <= 1'b0;
                    wren_q <= 1'b0;
                    addr_q <= '0;
                    din_q  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
